led_code_sequencer: RTL

Blink-code controller for the board's single status LED. Up to N_REQ requesters post events. A fixed-priority arbiter serves them one at a time, and each served requester k is shown as a burst of k+1 LED pulses followed by a gap. The block drives the LED pin directly, replacing a free-running counter blink, and sits between the design's event sources and the LED output.

---
 rtl/led_seq_pkg.sv | 39 +++
 rtl/led_code_sequencer_tick_prescaler.sv | 31 +++
 rtl/led_code_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types, default parameters and the arbiter helper for the status-LED blink-code sequencer.
package led_seq_pkg;

   localparam int unsigned DefNReq     = 4;
   localparam int unsigned DefTickDiv  = 1048576;
   localparam int unsigned DefOnTicks  = 2;
   localparam int unsigned DefOffTicks = 2;
   localparam int unsigned DefGapTicks = 8;

   // Arbiter helper works on the widest supported request vector.
   localparam int unsigned MaxReq = 8;
   localparam int unsigned MaxIdW = 3;

   typedef enum logic [1:0] {
      StIdle,
      StOn,
      StOff,
      StGap
   } led_state_e;

   typedef struct packed {
      logic              valid;
      logic [MaxIdW-1:0] idx;
   } sel_t;

   // Fixed priority: the lowest set bit wins.
   function automatic sel_t lowest_set_index(input logic [MaxReq-1:0] vec);
      sel_t s;
      s = '0;
      for (int i = MaxReq - 1; i >= 0; i--) begin
         if (vec[i]) begin
            s.valid = 1'b1;
            s.idx   = MaxIdW'(i);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/led_code_sequencer_tick_prescaler.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks while enabled; held at zero when disabled.
module tick_prescaler
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = DefTickDiv
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CntW = $clog2(TICK_DIV);

   logic [CntW-1:0] count_q;
   logic            at_top;

   assign at_top = (count_q == CntW'(TICK_DIV - 1));
   assign tick   = en & at_top;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (!en || at_top) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CntW'(1);
      end
   end

endmodule

// File: rtl/led_code_sequencer.sv
// Status-LED blink-code sequencer: requester k is shown as k+1 pulses followed by a gap,
// served one at a time by a fixed-priority arbiter over sticky pending flags.
module led_code_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned N_REQ     = DefNReq,
   parameter int unsigned TICK_DIV  = DefTickDiv,
   parameter int unsigned ON_TICKS  = DefOnTicks,
   parameter int unsigned OFF_TICKS = DefOffTicks,
   parameter int unsigned GAP_TICKS = DefGapTicks
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   output logic                     LED,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] active_id,
   output logic [N_REQ-1:0]         pending
);

   localparam int unsigned ID_W     = $clog2(N_REQ);
   localparam int unsigned MaxOnOff = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned MaxTicks = (MaxOnOff > GAP_TICKS) ? MaxOnOff : GAP_TICKS;
   localparam int unsigned CntW     = $clog2(MaxTicks + 1);
   localparam int unsigned RemW     = $clog2(N_REQ + 1);

   led_state_e       state_q, state_d;
   logic [CntW-1:0]  tcnt_q, tcnt_d;
   logic [RemW-1:0]  rem_q, rem_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             led_q, led_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] pend_q, pend_d, pend_clr;
   logic             tick;
   sel_t             sel;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != StIdle),
      .tick (tick)
   );

   assign sel = lowest_set_index(MaxReq'(pend_q));

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      rem_d    = rem_q;
      id_d     = id_q;
      pend_clr = '0;

      unique case (state_q)
         StIdle: begin
            if (sel.valid) begin
               pend_clr = N_REQ'(1) << sel.idx;
               id_d     = ID_W'(sel.idx);
               rem_d    = RemW'(sel.idx) + RemW'(1);
               tcnt_d   = '0;
               state_d  = StOn;
            end
         end
         StOn: begin
            if (tick) begin
               if (tcnt_q == CntW'(ON_TICKS - 1)) begin
                  rem_d   = rem_q - RemW'(1);
                  tcnt_d  = '0;
                  state_d = StOff;
               end else begin
                  tcnt_d = tcnt_q + CntW'(1);
               end
            end
         end
         StOff: begin
            if (tick) begin
               if (tcnt_q == CntW'(OFF_TICKS - 1)) begin
                  tcnt_d  = '0;
                  state_d = (rem_q != '0) ? StOn : StGap;
               end else begin
                  tcnt_d = tcnt_q + CntW'(1);
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (tcnt_q == CntW'(GAP_TICKS - 1)) begin
                  tcnt_d  = '0;
                  state_d = StIdle;
               end else begin
                  tcnt_d = tcnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A new request on the grant edge re-queues the event.
      pend_d = (pend_q & ~pend_clr) | req;
      led_d  = (state_d == StOn);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         tcnt_q  <= '0;
         rem_q   <= '0;
         id_q    <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         rem_q   <= rem_d;
         id_q    <= id_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
      end
   end

   assign LED       = led_q;
   assign busy      = busy_q;
   assign active_id = id_q;
   assign pending   = pend_q;

endmodule
